// File: rtl/ecliptic_fp_misc.sv
// ============================================================================
// ecliptic_fp_misc: binary32 sign injection, classify and compare/min/max.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ecliptic_fp_misc (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req,
  input  logic [1:0]  unit,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        ack,
  output logic [31:0] res,
  output logic        invalid
);

  localparam logic [1:0]  UNIT_SGNJ  = 2'b00;
  localparam logic [1:0]  UNIT_CLASS = 2'b01;
  localparam logic [1:0]  UNIT_CMP   = 2'b10;
  localparam logic [31:0] CANON_NAN  = 32'h7fc00000;

  logic        ack_q, ack_d;
  logic [31:0] res_q, res_d;
  logic        invalid_q, invalid_d;

  logic a_exp_ff, a_exp_0, a_frac_nz, a_nan, a_snan, a_zero;
  logic b_exp_ff, b_exp_0, b_frac_nz, b_nan, b_snan, b_zero;
  logic any_nan, any_snan, both_zero;
  logic lt, eq;
  logic [9:0]  cls;
  logic [31:0] result;
  logic        result_inv;

  always_comb begin
    a_exp_ff  = &src1[30:23];
    a_exp_0   = ~|src1[30:23];
    a_frac_nz = |src1[22:0];
    a_nan     = a_exp_ff & a_frac_nz;
    a_snan    = a_nan & ~src1[22];
    a_zero    = a_exp_0 & ~a_frac_nz;
    b_exp_ff  = &src2[30:23];
    b_exp_0   = ~|src2[30:23];
    b_frac_nz = |src2[22:0];
    b_nan     = b_exp_ff & b_frac_nz;
    b_snan    = b_nan & ~src2[22];
    b_zero    = b_exp_0 & ~b_frac_nz;
    any_nan   = a_nan | b_nan;
    any_snan  = a_snan | b_snan;
    both_zero = a_zero & b_zero;

    cls = {a_nan & src1[22],
           a_snan,
           ~src1[31] & a_exp_ff & ~a_frac_nz,
           ~src1[31] & ~a_exp_0 & ~a_exp_ff,
           ~src1[31] & a_exp_0 & a_frac_nz,
           ~src1[31] & a_zero,
           src1[31] & a_zero,
           src1[31] & a_exp_0 & a_frac_nz,
           src1[31] & ~a_exp_0 & ~a_exp_ff,
           src1[31] & a_exp_ff & ~a_frac_nz};

    // Sign-magnitude ordering: negative magnitudes compare inverted.
    eq = (src1 == src2) | both_zero;
    if (both_zero) begin
      lt = 1'b0;
    end else if (src1[31] != src2[31]) begin
      lt = src1[31];
    end else if (src1[31]) begin
      lt = src1[30:0] > src2[30:0];
    end else begin
      lt = src1[30:0] < src2[30:0];
    end

    result     = 32'd0;
    result_inv = 1'b0;
    case (unit)
      UNIT_SGNJ: begin
        case (op[1:0])
          2'b00:   result = {src2[31], src1[30:0]};
          2'b01:   result = {~src2[31], src1[30:0]};
          2'b10:   result = {src1[31] ^ src2[31], src1[30:0]};
          default: result = src1;
        endcase
      end
      UNIT_CLASS: result = {22'd0, cls};
      UNIT_CMP: begin
        case (op)
          3'b000: begin
            result     = {31'd0, ~any_nan & (lt | eq)};
            result_inv = any_nan;
          end
          3'b001: begin
            result     = {31'd0, ~any_nan & lt};
            result_inv = any_nan;
          end
          3'b010: begin
            result     = {31'd0, ~any_nan & eq};
            result_inv = any_snan;
          end
          3'b100, 3'b101: begin
            result_inv = any_snan;
            if (a_nan & b_nan) begin
              result = CANON_NAN;
            end else if (a_nan) begin
              result = src2;
            end else if (b_nan) begin
              result = src1;
            end else if (both_zero) begin
              result = op[0] ? {src1[31] & src2[31], 31'd0}
                             : {src1[31] | src2[31], 31'd0};
            end else begin
              result = (lt ^ op[0]) ? src1 : src2;
            end
          end
          default: begin
            result     = 32'd0;
            result_inv = 1'b0;
          end
        endcase
      end
      default: begin
        result     = 32'd0;
        result_inv = 1'b0;
      end
    endcase

    ack_d     = req;
    res_d     = req ? result : res_q;
    invalid_d = req ? result_inv : invalid_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ack_q     <= 1'b0;
      res_q     <= 32'd0;
      invalid_q <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      res_q     <= res_d;
      invalid_q <= invalid_d;
    end
  end

  assign ack     = ack_q;
  assign res     = res_q;
  assign invalid = invalid_q;

endmodule

`default_nettype wire

// File: tb/tb_ecliptic_fp_misc.sv
// ============================================================================
// tb_ecliptic_fp_misc: scoreboard bench with directed vectors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ecliptic_fp_misc;

  logic        clk;
  logic        nrst;
  logic        req;
  logic [1:0]  unit;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        ack;
  logic [31:0] res;
  logic        invalid;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        inv;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          failures;
  int          cyc;
  logic [31:0] last_res;
  logic        last_inv;

  ecliptic_fp_misc dut (
    .clk     (clk),
    .nrst    (nrst),
    .req     (req),
    .unit    (unit),
    .op      (op),
    .src1    (src1),
    .src2    (src2),
    .ack     (ack),
    .res     (res),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per ack and checks value and latency.
  always @(posedge clk) begin
    #1;
    if (nrst && ack) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_ack: got ack=1 res=%h, required no ack", res);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (res !== e.res || invalid !== e.inv || cyc != e.cyc + 1) begin
          failures = failures + 1;
          $display("FAIL %s: got res=%h inv=%b lat=%0d, required res=%h inv=%b lat=1",
                   e.name, res, invalid, cyc - e.cyc, e.res, e.inv);
        end
      end
    end
  end

  task automatic issue(input string name, input logic [1:0] u, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ei);
    exp_t e;
    @(negedge clk);
    req  = 1'b1;
    unit = u;
    op   = o;
    src1 = a;
    src2 = b;
    e.name = name;
    e.res  = er;
    e.inv  = ei;
    e.cyc  = cyc;
    sb.push_back(e);
    last_res = er;
    last_inv = ei;
  endtask

  task automatic check_idle(input string name, input logic [31:0] er, input logic ei);
    @(posedge clk);
    #1;
    checks = checks + 1;
    if (ack !== 1'b0 || res !== er || invalid !== ei) begin
      failures = failures + 1;
      $display("FAIL %s: got ack=%b res=%h inv=%b, required ack=0 res=%h inv=%b",
               name, ack, res, invalid, er, ei);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nrst     = 1'b0;
    req      = 1'b1;
    unit     = 2'b01;
    op       = 3'b000;
    src1     = 32'h3f800000;
    src2     = 32'h00000000;
    last_res = 32'd0;
    last_inv = 1'b0;

    // Reset held with req asserted: outputs stay cleared.
    check_idle("reset_cyc0", 32'd0, 1'b0);
    check_idle("reset_cyc1", 32'd0, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    req  = 1'b0;

    issue("post_reset_class", 2'b01, 3'b000, 32'h3f800000, 32'h0, 32'h00000040, 1'b0);

    issue("sgnj_a",  2'b00, 3'b000, 32'h3f800000, 32'hcf800000, 32'hbf800000, 1'b0);
    issue("sgnj_b",  2'b00, 3'b000, 32'h7f800001, 32'h3f800000, 32'h7f800001, 1'b0);
    issue("sgnjn",   2'b00, 3'b001, 32'h3f800000, 32'h3f800000, 32'hbf800000, 1'b0);
    issue("sgnjx",   2'b00, 3'b110, 32'hbf800000, 32'hcf800000, 32'h3f800000, 1'b0);
    issue("sgnj_11", 2'b00, 3'b011, 32'hc0000000, 32'h00000000, 32'hc0000000, 1'b0);

    issue("cls_pnorm", 2'b01, 3'b101, 32'h3f800000, 32'hffffffff, 32'h040, 1'b0);
    issue("cls_snan",  2'b01, 3'b000, 32'h7f800001, 32'h0, 32'h100, 1'b0);
    issue("cls_qnan",  2'b01, 3'b000, 32'h7fc00000, 32'h0, 32'h200, 1'b0);
    issue("cls_nzero", 2'b01, 3'b000, 32'h80000000, 32'h0, 32'h008, 1'b0);
    issue("cls_psub",  2'b01, 3'b000, 32'h00000001, 32'h0, 32'h020, 1'b0);
    issue("cls_ninf",  2'b01, 3'b000, 32'hff800000, 32'h0, 32'h001, 1'b0);
    issue("cls_nsub",  2'b01, 3'b000, 32'h80000001, 32'h0, 32'h004, 1'b0);
    issue("cls_nnorm", 2'b01, 3'b000, 32'hbf800000, 32'h0, 32'h002, 1'b0);
    issue("cls_pinf",  2'b01, 3'b000, 32'h7f800000, 32'h0, 32'h080, 1'b0);
    issue("cls_pzero", 2'b01, 3'b000, 32'h00000000, 32'h0, 32'h010, 1'b0);
    issue("cls_nqnan", 2'b01, 3'b000, 32'hffc00000, 32'h0, 32'h200, 1'b0);

    issue("fmax_num",   2'b10, 3'b101, 32'h3f800000, 32'hcf800000, 32'h3f800000, 1'b0);
    issue("fmax_snan",  2'b10, 3'b101, 32'h7f800001, 32'h3f800000, 32'h3f800000, 1'b1);
    issue("fmax_zero",  2'b10, 3'b101, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0);
    issue("fmax_zero2", 2'b10, 3'b101, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
    issue("fmin_nans",  2'b10, 3'b100, 32'h7fc00000, 32'h7f800001, 32'h7fc00000, 1'b1);
    issue("fmin_zero",  2'b10, 3'b100, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0);
    issue("fmin_zero2", 2'b10, 3'b100, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0);
    issue("fmin_qnan",  2'b10, 3'b100, 32'h3f800000, 32'h7fc00000, 32'h3f800000, 1'b0);
    issue("fmin_neg",   2'b10, 3'b100, 32'hbf800000, 32'hc0000000, 32'hc0000000, 1'b0);

    issue("feq_zeros",  2'b10, 3'b010, 32'h00000000, 32'h80000000, 32'h1, 1'b0);
    issue("flt_mixed",  2'b10, 3'b001, 32'hbf800000, 32'h3f800000, 32'h1, 1'b0);
    issue("flt_neg",    2'b10, 3'b001, 32'hc0000000, 32'hbf800000, 32'h1, 1'b0);
    issue("flt_rev",    2'b10, 3'b001, 32'h3f800000, 32'hbf800000, 32'h0, 1'b0);
    issue("fle_equal",  2'b10, 3'b000, 32'h3f800000, 32'h3f800000, 32'h1, 1'b0);
    issue("fle_qnan",   2'b10, 3'b000, 32'h7fc00000, 32'h3f800000, 32'h0, 1'b1);
    issue("feq_qnan",   2'b10, 3'b010, 32'h7fc00000, 32'h3f800000, 32'h0, 1'b0);
    issue("feq_snan",   2'b10, 3'b010, 32'h7f800001, 32'h3f800000, 32'h0, 1'b1);
    issue("cmp_badop",  2'b10, 3'b011, 32'h3f800000, 32'h3f800000, 32'h0, 1'b0);
    issue("unit_rsvd",  2'b11, 3'b000, 32'h3f800000, 32'h3f800000, 32'h0, 1'b0);
    issue("fle_last",   2'b10, 3'b000, 32'h00000001, 32'h00000002, 32'h1, 1'b0);

    // Drop req: ack falls while res and invalid hold.
    @(negedge clk);
    req  = 1'b0;
    src1 = 32'hdeadbeef;
    unit = 2'b00;
    check_idle("hold_c1", last_res, last_inv);
    check_idle("hold_c2", last_res, last_inv);

    repeat (3) @(posedge clk);
    #2;
    checks = checks + 1;
    if (sb.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain: got %0d pending results, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ecliptic_fp_misc.md
# ecliptic_fp_misc

Single-cycle-latency unit for the non-arithmetic single-precision (IEEE-754 binary32) operations of the ecliptic FPU: sign injection, classification, and comparison/min/max. It sits beside the FPU arithmetic pipes and is fed from the FP register-read stage. Results return through a req/ack pulse, one result per cycle, fully pipelined.

## Interface
- No parameters; data width is fixed at 32 bits.
- clk  in  1  clock; all state updates on the rising edge.
- nrst  in  1  asynchronous, active-low reset.
- req  in  1  operation valid this cycle.
- unit  in  2  function select: 00 sign-injection, 01 classify, 10 compare/min/max, 11 reserved.
- op  in  3  sub-operation; meaning depends on unit.
- src1  in  32  operand 1; the classify operand.
- src2  in  32  operand 2; ignored by classify.
- ack  out  1  result valid; asserted exactly one cycle after req.
- res  out  32  result.
- invalid  out  1  IEEE invalid-operation flag for this result.

## Operation
- Field decode: sign = [31], exp = [30:23], frac = [22:0].
- NaN: exp = FF and frac != 0. It is a quiet NaN (qNaN) if frac[22] = 1, and a signaling NaN (sNaN) if frac[22] = 0.
- Sign injection (unit 00); invalid is always 0:
  - op[1:0] = 00 (SGNJ): res = {src2[31], src1[30:0]}.
  - op[1:0] = 01 (SGNJN): res = {~src2[31], src1[30:0]}.
  - op[1:0] = 10 (SGNJX): res = {src1[31]^src2[31], src1[30:0]}.
  - op[1:0] = 11: res = src1.
  - op[2] is ignored.
- Classify (unit 01); op is ignored and invalid is 0. res = {22'b0, class[9:0]}, one-hot.
  - class bits, MSB to LSB: [9] qNaN, [8] sNaN, [7] +Inf, [6] +normal, [5] +subnormal, [4] +0, [3] -0, [2] -subnormal, [1] -normal, [0] -Inf.
  - Subnormal: exp = 0 and frac != 0. Normal: exp is neither 0 nor FF.
  - NaN classes ignore the sign bit.
- Compare (unit 10):
  - op = 000 FLE, 001 FLT, 010 FEQ: res = {31'b0, bool}.
    - Ordering is IEEE numeric ordering; +0 and -0 compare equal.
    - Any NaN operand forces the result to 0.
    - FEQ: invalid = 1 only if an operand is an sNaN.
    - FLT/FLE: invalid = 1 if any operand is a NaN.
  - op = 100 FMIN, 101 FMAX: res = the smaller or larger operand.
    - min(-0, +0) = -0 and max(-0, +0) = +0, in either operand order.
    - Exactly one operand NaN: res = the other operand.
    - Both operands NaN: res = canonical qNaN 32'h7fc00000.
    - invalid = 1 if any operand is an sNaN.
  - Other op codes: res = 0, invalid = 0.
- Reserved unit 11: res = 0, invalid = 0.

## Timing
- Reset (nrst low, asynchronous): ack = 0, res = 0, invalid = 0. These hold while nrst is low.
- Rising edge with req = 1: ack <= 1, and res and invalid are registered from the current inputs.
- Rising edge with req = 0: ack <= 0, and res and invalid hold their previous values.
- Latency is exactly 1 cycle; throughput is 1 per cycle, and back-to-back req produces back-to-back ack.
- There is no backpressure and no internal state beyond the output registers.
- Inputs are sampled only on the edge; changing inputs mid-cycle has no effect until the next edge.
- Reset asserted mid-stream drops any in-flight result; the first ack after reset release follows the first req.

## Test plan
- Reset: hold nrst low for 2 cycles with req = 1 -> ack = 0, res = 0, invalid = 0 throughout. Release, then one edge with req = 1 -> ack = 1 on the following cycle.
- Sign injection, SGNJ, back-to-back, with ack = 1 on both consecutive cycles:
  - src1 = 3f800000, src2 = cf800000 -> res = bf800000.
  - Next cycle src1 = 7f800001, src2 = 3f800000 -> res = 7f800001.
- Classify:
  - 3f800000 -> res = 0x040.
  - 7f800001 -> res = 0x100.
  - 7fc00000 -> res = 0x200.
  - 80000000 -> res = 0x008.
  - 00000001 -> res = 0x020.
  - ff800000 -> res = 0x001.
- FMAX (op 101):
  - (3f800000, cf800000) -> res = 3f800000, invalid = 0.
  - (7f800001, 3f800000) -> res = 3f800000, invalid = 1.
  - (00000000, 80000000) -> res = 00000000.
- FMIN with NaNs:
  - (7fc00000, 7f800001) -> res = 7fc00000, invalid = 1.
  - (80000000, 00000000) -> res = 80000000.
- Compares:
  - FEQ(00000000, 80000000) -> 1.
  - FLT(bf800000, 3f800000) -> 1.
  - FLE(7fc00000, 3f800000) -> 0, invalid = 1.
  - FEQ(7fc00000, 3f800000) -> 0, invalid = 0.
  - Drop req -> ack = 0 and res holds its last value.
